la_iofilter: RTL

Parametrised multi-channel successor to the single-channel input pad wrapper. The block instantiates N IHP `sg13g2_IOPadIn` cells and adds per-channel clock-domain synchronisation, a programmable debounce/glitch filter and sticky edge-event flags. It sits on the padring boundary and feeds clean, registered input levels and edge events to core logic such as GPIO and interrupt controllers.

---
 rtl/sg13g2_IOPadIn.sv | 29 ++
 rtl/la_iofilter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sg13g2_IOPadIn.sv
// sg13g2_IOPadIn
// Behavioural stand-in for the IHP SG13G2 input-only pad cell. It lets the
// filter elaborate and simulate without the foundry library. In a real
// implementation flow the library cell replaces this model.
//
// Ports:
//   pad    - pad-side signal (read only, the cell has no output driver)
//   p2c    - pad-to-core level
//   iovdd  - io supply
//   iovss  - io ground
//   vdd    - core supply
//   vss    - core ground
module sg13g2_IOPadIn (
  inout  wire pad,
  output wire p2c,
  inout  wire iovdd,
  inout  wire iovss,
  inout  wire vdd,
  inout  wire vss
);

  // The model passes the pad level straight through.
  assign p2c = pad;

  // The supplies only matter to the physical cell.
  wire unused_supply;
  assign unused_supply = ^{iovdd, iovss, vdd, vss};

endmodule

// File: rtl/la_iofilter.sv
// la_iofilter
// Multi-channel input pad wrapper. Each channel has an IHP input pad, an
// input-enable gate, a SYNCW-deep synchroniser, and a debounce filter. The
// debounce threshold is shared by all channels. Each channel also has
// optional sticky rise/fall event flags.
//
// Build option:
//   LA_IOFILTER_EVENT_EN - when defined, the rise/fall flag registers and the
//                          evclr clear logic are built. When undefined,
//                          rise/fall are tied low and evclr is ignored.
//
// Ports:
//   clk     - core clock, all state updates on the rising edge
//   reset   - synchronous active-high reset
//   pad     - N pad signals
//   vdd/vss/vddio/vssio - core and io supplies
//   ie      - per-channel input enable (1 = active)
//   pe/ps   - pull enable/select, ignored (the pad cell has no pulls)
//   thresh  - debounce threshold
//   z_raw   - unregistered pad level gated by ie
//   z       - filtered level
//   rise    - sticky 0->1 event on z
//   fall    - sticky 1->0 event on z
//   evclr   - per-channel clear of rise/fall
//   ioring  - generic io ring, passed through untouched
//   cfg     - generic config, currently unused
module la_iofilter #(
  parameter int N     = 4,
  parameter int SYNCW = 2,
  parameter int CNTW  = 8,
  parameter     PROP  = "DEFAULT",
  parameter     SIDE  = "NO",
  parameter int CFGW  = 16,
  parameter int RINGW = 8
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [N-1:0]     pad,
  inout  wire              vdd,
  inout  wire              vss,
  inout  wire              vddio,
  inout  wire              vssio,
  input  logic [N-1:0]     ie,
  input  logic [N-1:0]     pe,
  input  logic [N-1:0]     ps,
  input  logic [CNTW-1:0]  thresh,
  output logic [N-1:0]     z_raw,
  output logic [N-1:0]     z,
  output logic [N-1:0]     rise,
  output logic [N-1:0]     fall,
  input  logic [N-1:0]     evclr,
  inout  wire  [RINGW-1:0] ioring,
  input  logic [CFGW-1:0]  cfg
);

  localparam bit PROP_FIXED = (PROP == "FIXED");
  localparam bit SIDE_KNOWN = (SIDE == "NO") || (SIDE == "SO") ||
                              (SIDE == "EA") || (SIDE == "WE");

  wire  [N-1:0]    p2c;
  logic [N-1:0]    sync_q [SYNCW];
  logic [N-1:0]    s;
  logic [CNTW-1:0] cnt [N];
  logic [N-1:0]    upd;

  // Every cell property maps to the same input pad cell. The two branches are
  // kept separate so that a future variant cell can be added in one place.
  for (genvar i = 0; i < N; i++) begin : g_pad
    if (PROP_FIXED) begin : g_fixed
      sg13g2_IOPadIn u_pad (
        .pad   (pad[i]),
        .p2c   (p2c[i]),
        .iovdd (vddio),
        .iovss (vssio),
        .vdd   (vdd),
        .vss   (vss)
      );
    end else begin : g_default
      sg13g2_IOPadIn u_pad (
        .pad   (pad[i]),
        .p2c   (p2c[i]),
        .iovdd (vddio),
        .iovss (vssio),
        .vdd   (vdd),
        .vss   (vss)
      );
    end
  end

  assign z_raw = p2c & ie;
  assign s     = sync_q[SYNCW-1];

  // The pulls, config bus, ring and side selection have no function in this
  // cell. They are folded together here so that they stay visible on the
  // interface.
  logic unused_inputs;
  assign unused_inputs = ^{pe, ps, cfg, ioring, evclr, PROP_FIXED, SIDE_KNOWN};

  // Synchroniser chain. Stage 0 samples the asynchronous gated pad level.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNCW; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= z_raw;
      for (int k = 1; k < SYNCW; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // A channel commits a new level once it has disagreed with z and the
  // disagreement count has reached the threshold. The >= compare means a
  // lowered threshold takes effect right away. It also means the counter is
  // cleared before it could ever wrap.
  always_comb begin
    upd = '0;
    for (int i = 0; i < N; i++) begin
      upd[i] = (s[i] != z[i]) && (cnt[i] >= thresh);
    end
  end

  // Debounce counters and filtered level.
  always_ff @(posedge clk) begin
    if (reset) begin
      z <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (s[i] == z[i]) begin
          cnt[i] <= '0;
        end else if (upd[i]) begin
          z[i]   <= s[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef LA_IOFILTER_EVENT_EN
  // Sticky edge flags. They are set on the same edge that z changes. A set
  // and a clear in the same cycle resolve to set.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= (rise & ~evclr) | (upd & s);
      fall <= (fall & ~evclr) | (upd & ~s);
    end
  end
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule
